// File: rtl/telem_pkg.sv
// Shared definitions for the telemetry framer: FSM state encoding, default sync bytes
// and the CRC-8 polynomial used when TELEM_CRC8_EN is defined.
package telem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_SEQ     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CRC     = 3'd5
    } state_t;

    localparam logic [7:0] DEF_HDR0  = 8'hDE;
    localparam logic [7:0] DEF_HDR1  = 8'hAD;
    localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/telem_crc8.sv
// Byte-wide CRC-8 accumulator (MSB first, no reflection, no final XOR).
// Instantiated by telem_framer only when TELEM_CRC8_EN is defined.
module telem_crc8 import telem_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] next_crc;

    // Eight shift/XOR steps fold one whole byte into the register per cycle.
    always_comb begin
        next_crc = crc_out ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            next_crc = next_crc[7] ? ((next_crc << 1) ^ CRC8_POLY) : (next_crc << 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_out <= 8'h00;
        end else if (clear) begin
            crc_out <= 8'h00;
        end else if (en) begin
            crc_out <= next_crc;
        end
    end

endmodule

// File: rtl/telem_framer.sv
// Telemetry framer: decimates sample sets and streams HDR0, HDR1, seq, payload bytes to a UART.
// Define TELEM_CRC8_EN to append a CRC-8 byte over seq and payload.
module telem_framer import telem_pkg::*; #(
    parameter int          NUM_CH = 3,
    parameter int          DATA_W = 16,
    parameter logic [7:0]  HDR0   = DEF_HDR0,
    parameter logic [7:0]  HDR1   = DEF_HDR1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic [3:0]               decim,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [7:0]               overrun_cnt,
    output logic [7:0]               seq
);

    localparam int NBYTES = NUM_CH * DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                   state;
    logic [7:0]               tx_byte;
    logic [3:0]               dec_cnt;
    logic [NUM_CH*DATA_W-1:0] snapshot;
    logic [IDX_W-1:0]         byte_idx;
    logic [IDX_W-1:0]         sel_idx;
    logic [7:0]               pay_byte;
    logic                     xfer;

    assign xfer    = tx_valid && tx_ready;
    assign busy    = (state != ST_IDLE);
    assign sel_idx = (state == ST_PAYLOAD) ? byte_idx + 1'b1 : '0;

    // Byte to load next: channel 0 sits in the MSBs, so byte 0 is the top byte.
    always_comb begin
        pay_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                pay_byte = snapshot[(NBYTES-1-i)*8 +: 8];
            end
        end
    end

`ifdef TELEM_CRC8_EN
    logic [7:0] crc_val;

    telem_crc8 u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_HDR0),
        .en      (xfer && (state == ST_SEQ || state == ST_PAYLOAD)),
        .byte_in (tx_byte),
        .crc_out (crc_val)
    );

    assign tx_data = (state == ST_CRC) ? crc_val : tx_byte;
`else
    assign tx_data = tx_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tx_valid    <= 1'b0;
            tx_byte     <= 8'h00;
            seq         <= 8'h00;
            overrun_cnt <= 8'h00;
            dec_cnt     <= 4'd0;
            snapshot    <= '0;
            byte_idx    <= '0;
        end else begin
            // Any sample arriving while a frame is in flight is lost, including the final byte cycle.
            if (state != ST_IDLE && sample_valid && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        if (dec_cnt == decim) begin
                            snapshot <= sample_data;
                            dec_cnt  <= 4'd0;
                            state    <= ST_HDR0;
                            tx_valid <= 1'b1;
                            tx_byte  <= HDR0;
                        end else begin
                            dec_cnt <= dec_cnt + 4'd1;
                        end
                    end
                end
                ST_HDR0: begin
                    if (xfer) begin
                        state   <= ST_HDR1;
                        tx_byte <= HDR1;
                    end
                end
                ST_HDR1: begin
                    if (xfer) begin
                        state   <= ST_SEQ;
                        tx_byte <= seq;
                    end
                end
                ST_SEQ: begin
                    if (xfer) begin
                        state    <= ST_PAYLOAD;
                        byte_idx <= '0;
                        tx_byte  <= pay_byte;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        if (byte_idx == LAST_IDX) begin
`ifdef TELEM_CRC8_EN
                            state <= ST_CRC;
`else
                            state    <= ST_IDLE;
                            tx_valid <= 1'b0;
                            tx_byte  <= 8'h00;
                            seq      <= seq + 8'd1;
`endif
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            tx_byte  <= pay_byte;
                        end
                    end
                end
`ifdef TELEM_CRC8_EN
                ST_CRC: begin
                    if (xfer) begin
                        state    <= ST_IDLE;
                        tx_valid <= 1'b0;
                        tx_byte  <= 8'h00;
                        seq      <= seq + 8'd1;
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telem_framer.sv
// Directed self-checking bench for telem_framer (default parameters); follows TELEM_CRC8_EN.
module tb_telem_framer;

    localparam int NB = 6;
`ifdef TELEM_CRC8_EN
    localparam int FRAME_LEN = NB + 4;
`else
    localparam int FRAME_LEN = NB + 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [47:0] sample_data;
    logic [3:0]  decim;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic [7:0]  seq;

    int assertCount = 0;
    int failCount   = 0;
    int holdErr     = 0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData  = 8'h00;
    logic [7:0] rxq[$];

    telem_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .decim        (decim),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .seq          (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitor: capture transferred bytes and flag data changing under backpressure.
    always @(negedge clk) begin
        if (rst_n && prevStall && (tx_valid !== 1'b1 || tx_data !== prevData)) holdErr++;
        prevStall = rst_n && tx_valid && !tx_ready;
        prevData  = tx_data;
        if (rst_n && tx_valid && tx_ready) rxq.push_back(tx_data);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expVal);
        assertCount++;
        if (got !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expVal);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [47:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input bit randReady);
        int n = 0;
        while (busy && n < limit) begin
            if (randReady) tx_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (busy) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
        tx_ready = 1'b1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rxq.delete();
    endtask

    function automatic logic [7:0] crcStep(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c = crc ^ b;
        for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    function automatic logic [47:0] mkSample(input int k);
        logic [15:0] a = 16'(k);
        return {a, a * 16'd257, a | 16'hF000};
    endfunction

    // Pops one frame from the capture queue and compares it byte by byte.
    task automatic checkFrame(input string tag, input logic [7:0] expSeq, input logic [47:0] d);
        logic [7:0] expq[$];
        logic [7:0] crc = 8'h00;
        logic [31:0] got;
        expq.push_back(8'hDE);
        expq.push_back(8'hAD);
        expq.push_back(expSeq);
        crc = crcStep(crc, expSeq);
        for (int i = 0; i < NB; i++) begin
            expq.push_back(d[47-8*i -: 8]);
            crc = crcStep(crc, d[47-8*i -: 8]);
        end
`ifdef TELEM_CRC8_EN
        expq.push_back(crc);
`endif
        for (int i = 0; i < expq.size(); i++) begin
            got = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h100;
            checkOutput($sformatf("%s_byte%0d", tag, i), got, {24'h0, expq[i]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        decim        = 4'd0;
        tx_ready     = 1'b1;
        #2;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_seq", seq, 0);
        checkOutput("rst_overrun", overrun_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame: DE AD 00 12 34 AB CD 00 FF
        applyStimulus(48'h1234_ABCD_00FF);
        checkOutput("basic_first_valid", tx_valid, 1);
        checkOutput("basic_first_byte", tx_data, 32'hDE);
        checkOutput("basic_busy", busy, 1);
        waitIdle(50, 1'b0);
        checkOutput("basic_valid_low", tx_valid, 0);
        checkFrame("basic", 8'h00, 48'h1234_ABCD_00FF);
        checkOutput("basic_seq_next", seq, 1);
        checkOutput("basic_leftover", rxq.size(), 0);

        // Random backpressure
        applyStimulus(48'h5A5A_0001_FFEE);
        waitIdle(400, 1'b1);
        checkFrame("bp", 8'h01, 48'h5A5A_0001_FFEE);
        checkOutput("bp_hold", holdErr, 0);

        // Three drops during a stalled frame; later data changes must not leak in
        tx_ready = 1'b0;
        applyStimulus(48'hCAFE_BEEF_0123);
        tick();
        for (int i = 0; i < 3; i++) begin
            sample_data  = 48'hFFFF_FFFF_FFFF;
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            tick();
        end
        tx_ready = 1'b1;
        waitIdle(50, 1'b0);
        checkOutput("ovr_cnt3", overrun_cnt, 3);
        checkFrame("ovr", 8'h02, 48'hCAFE_BEEF_0123);
        checkOutput("ovr_leftover", rxq.size(), 0);

        // Sample on the cycle of the last transfer is dropped
        applyStimulus(48'h0102_0304_0506);
        repeat (FRAME_LEN - 1) tick();
        sample_data  = 48'h7777_7777_7777;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (5) tick();
        checkOutput("lastdrop_busy", busy, 0);
        checkOutput("lastdrop_cnt", overrun_cnt, 4);
        checkFrame("lastdrop", 8'h03, 48'h0102_0304_0506);
        checkOutput("lastdrop_leftover", rxq.size(), 0);

        // 300 drops saturate the counter
        tx_ready = 1'b0;
        applyStimulus(48'h1111_2222_3333);
        sample_valid = 1'b1;
        repeat (300) tick();
        sample_valid = 1'b0;
        checkOutput("sat_cnt", overrun_cnt, 32'hFF);
        tx_ready = 1'b1;
        waitIdle(50, 1'b0);
        checkFrame("sat", 8'h04, 48'h1111_2222_3333);

        // Decimation by 3: samples 3, 6, 9 framed
        resetDut();
        checkOutput("dec_rst_seq", seq, 0);
        checkOutput("dec_rst_ovr", overrun_cnt, 0);
        decim = 4'd2;
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(mkSample(k));
            repeat (20) tick();
        end
        checkOutput("dec_total_bytes", rxq.size(), 3 * FRAME_LEN);
        checkFrame("dec_s3", 8'h00, mkSample(3));
        checkFrame("dec_s6", 8'h01, mkSample(6));
        checkFrame("dec_s9", 8'h02, mkSample(9));
        checkOutput("dec_seq_next", seq, 3);

        // Sequence wrap over 257 frames
        resetDut();
        decim = 4'd0;
        for (int f = 1; f <= 257; f++) begin
            applyStimulus(mkSample(f));
            waitIdle(50, 1'b0);
            if (f == 256)      checkFrame("wrap256", 8'hFF, mkSample(f));
            else if (f == 257) checkFrame("wrap257", 8'h00, mkSample(f));
            else               rxq.delete();
        end
        checkOutput("wrap_seq_next", seq, 1);

        // Reset during PAYLOAD
        applyStimulus(mkSample(1));
        repeat (4) tick();
        checkOutput("prerst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx_valid", tx_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_tx_data", tx_data, 0);
        checkOutput("midrst_seq", seq, 0);
        rxq.delete();
        tick();
        tick();
        checkOutput("midrst_no_bytes", rxq.size(), 0);
        rst_n = 1'b1;
        tick();
        applyStimulus(48'h9876_5432_10FE);
        waitIdle(50, 1'b0);
        checkFrame("postrst", 8'h00, 48'h9876_5432_10FE);
        checkOutput("postrst_leftover", rxq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
